// File: rtl/nibble_datapath.sv
// nibble_datapath: fetch/execute datapath of the nibble processor.
// Holds PC, IR, operand latch B and the accumulator, and executes the
// control word issued by the central control FSM. The opcode field of the
// IR is returned to the FSM on `op`.
// Instruction word: {op[1:0], imm[DW-1:0]}.
// Optional feature: define NIBBLE_ZFLAG_EN to build the registered
// accumulator-zero flag; otherwise `zero` is tied low.
module nibble_datapath #(
    parameter int PC_W     = 4,
    parameter int DW       = 4,
    parameter int RESET_PC = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      ctl,
    output logic [PC_W-1:0] mem_addr,
    input  logic [DW+1:0]   mem_rdata,
    output logic [1:0]      op,
    output logic [DW-1:0]   acc,
    output logic            carry,
    output logic            halted,
    output logic            err,
    output logic            zero
);

    typedef enum logic [1:0] {
        PH_IDLE   = 2'b00,
        PH_DECODE = 2'b01,
        PH_EXEC   = 2'b10
    } phase_t;

    localparam logic [1:0] CTL_HALT  = 2'b00;
    localparam logic [1:0] CTL_EXEC  = 2'b01;
    localparam logic [1:0] CTL_FETCH = 2'b10;
    localparam logic [1:0] CTL_ILL   = 2'b11;

    localparam logic [1:0] OP_LDI = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;

    // Architectural state
    logic [PC_W-1:0] pc_r;
    logic [DW+1:0]   ir_r;
    logic [DW-1:0]   b_r;
    logic [DW-1:0]   acc_r;
    logic            carry_r;
    logic            halted_r;
    logic            err_r;
    phase_t          phase_r;

    // Next-state values
    logic [PC_W-1:0] pc_s;
    logic [DW+1:0]   ir_s;
    logic [DW-1:0]   b_s;
    logic [DW-1:0]   acc_s;
    logic            carry_s;
    logic            halted_s;
    logic            err_s;
    phase_t          phase_s;

    logic [1:0]      op_s;
    logic [DW-1:0]   imm_s;
    logic [DW:0]     sum_s;

    assign op_s  = ir_r[DW+1:DW];
    assign imm_s = ir_r[DW-1:0];
    // Carry-out is the extra top bit of a DW+1 bit add.
    assign sum_s = {1'b0, acc_r} + {1'b0, b_r};

    // Next-state decode of the control word against the current phase
    always_comb begin
        pc_s     = pc_r;
        ir_s     = ir_r;
        b_s      = b_r;
        acc_s    = acc_r;
        carry_s  = carry_r;
        halted_s = halted_r;
        err_s    = err_r;
        phase_s  = phase_r;
        case (ctl)
            CTL_FETCH: begin
                ir_s    = mem_rdata;
                pc_s    = pc_r + PC_W'(1);
                phase_s = PH_DECODE;
            end
            CTL_EXEC: begin
                case (phase_r)
                    PH_DECODE: begin
                        case (op_s)
                            OP_LDI: begin
                                acc_s   = imm_s;
                                phase_s = PH_IDLE;
                            end
                            OP_ADD: begin
                                b_s     = imm_s;
                                phase_s = PH_EXEC;
                            end
                            default: begin
                                halted_s = 1'b1;
                                phase_s  = PH_IDLE;
                            end
                        endcase
                    end
                    PH_EXEC: begin
                        acc_s   = sum_s[DW-1:0];
                        carry_s = sum_s[DW];
                        phase_s = PH_IDLE;
                    end
                    default: begin
                        // Execute request with no instruction pending is ignored.
                        phase_s = phase_r;
                    end
                endcase
            end
            CTL_ILL: begin
                err_s = 1'b1;
            end
            default: begin
                // Halt: every register holds.
                phase_s = phase_r;
            end
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r     <= PC_W'(RESET_PC);
            ir_r     <= '0;
            b_r      <= '0;
            acc_r    <= '0;
            carry_r  <= 1'b0;
            halted_r <= 1'b0;
            err_r    <= 1'b0;
            phase_r  <= PH_IDLE;
        end else begin
            pc_r     <= pc_s;
            ir_r     <= ir_s;
            b_r      <= b_s;
            acc_r    <= acc_s;
            carry_r  <= carry_s;
            halted_r <= halted_s;
            err_r    <= err_s;
            phase_r  <= phase_s;
        end
    end

`ifdef NIBBLE_ZFLAG_EN
    logic zero_r;
    logic acc_wr_s;

    // An accumulator write happens on LDI decode or ADD execute
    always_comb begin
        acc_wr_s = (ctl == CTL_EXEC) &&
                   (((phase_r == PH_DECODE) && (op_s == OP_LDI)) ||
                    (phase_r == PH_EXEC));
    end

    // Zero flag tracks the value written into the accumulator
    always_ff @(posedge clk) begin
        if (reset) begin
            zero_r <= 1'b0;
        end else if (acc_wr_s) begin
            zero_r <= (acc_s == '0);
        end else begin
            zero_r <= zero_r;
        end
    end

    assign zero = zero_r;
`else
    assign zero = 1'b0;
`endif

    assign mem_addr = pc_r;
    assign op       = op_s;
    assign acc      = acc_r;
    assign carry    = carry_r;
    assign halted   = halted_r;
    assign err      = err_r;

endmodule

// File: tb/tb_nibble_datapath.sv
// Directed self-checking bench for nibble_datapath. The ROM is modelled
// here as a combinational array indexed by mem_addr.
module tb_nibble_datapath;

`ifdef NIBBLE_ZFLAG_EN
    localparam logic ZF = 1'b1;
`else
    localparam logic ZF = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic [1:0] ctl;
    logic [3:0] mem_addr;
    logic [5:0] mem_rdata;
    logic [1:0] op;
    logic [3:0] acc;
    logic       carry;
    logic       halted;
    logic       err;
    logic       zero;

    logic [5:0] rom [16];
    int total;
    int bad;

    assign mem_rdata = rom[mem_addr];

    nibble_datapath #(.PC_W(4), .DW(4), .RESET_PC(0)) dut (
        .clk       (clk),
        .reset     (reset),
        .ctl       (ctl),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .op        (op),
        .acc       (acc),
        .carry     (carry),
        .halted    (halted),
        .err       (err),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic [1:0] c);
        ctl = c;
        @(posedge clk);
        #1;
    endtask

    task automatic fill_rom(input logic [5:0] w);
        for (int i = 0; i < 16; i++) rom[i] = w;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(2'b00);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(2'b00);
        step(2'b00);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(2'b00);
            total++;
            if ({mem_addr, op, acc, carry, halted, err, zero} !== 15'd0) begin
                bad++;
                $display("FAIL reset_hold cyc%0d got pc=%0d op=%0d acc=%0d c=%0b h=%0b e=%0b z=%0b want all 0",
                         i, mem_addr, op, acc, carry, halted, err, zero);
            end
        end
    endtask

    task automatic test_ldi();
        step(2'b10);
        total++;
        if ({op, mem_addr} !== {2'b00, 4'd1}) begin
            bad++;
            $display("FAIL ldi_fetch got op=%0d pc=%0d want op=0 pc=1", op, mem_addr);
        end
        step(2'b01);
        total++;
        if ({acc, zero, mem_addr} !== {4'd5, 1'b0, 4'd1}) begin
            bad++;
            $display("FAIL ldi_exec got acc=%0d z=%0b pc=%0d want acc=5 z=0 pc=1", acc, zero, mem_addr);
        end
    endtask

    task automatic test_add();
        step(2'b10);
        total++;
        if (op !== 2'b01) begin
            bad++;
            $display("FAIL add_op got=%0d want=1", op);
        end
        step(2'b01);
        total++;
        if (acc !== 4'd5) begin
            bad++;
            $display("FAIL add_decode_acc got=%0d want=5", acc);
        end
        step(2'b01);
        total++;
        if ({acc, carry} !== {4'd8, 1'b0}) begin
            bad++;
            $display("FAIL add3 got acc=%0d c=%0b want acc=8 c=0", acc, carry);
        end
        step(2'b10);
        step(2'b01);
        step(2'b01);
        total++;
        if ({acc, carry, mem_addr} !== {4'd2, 1'b1, 4'd3}) begin
            bad++;
            $display("FAIL add10 got acc=%0d c=%0b pc=%0d want acc=2 c=1 pc=3", acc, carry, mem_addr);
        end
    endtask

    task automatic test_spurious_exec();
        step(2'b01);
        total++;
        if ({acc, carry, mem_addr} !== {4'd2, 1'b1, 4'd3}) begin
            bad++;
            $display("FAIL spurious_exec got acc=%0d c=%0b pc=%0d want acc=2 c=1 pc=3", acc, carry, mem_addr);
        end
    endtask

    task automatic test_halt();
        step(2'b10);
        total++;
        if ({op, halted, mem_addr} !== {2'b10, 1'b0, 4'd4}) begin
            bad++;
            $display("FAIL halt_fetch got op=%0d h=%0b pc=%0d want op=2 h=0 pc=4", op, halted, mem_addr);
        end
        step(2'b01);
        total++;
        if ({halted, acc, carry} !== {1'b1, 4'd2, 1'b1}) begin
            bad++;
            $display("FAIL halt_exec got h=%0b acc=%0d c=%0b want h=1 acc=2 c=1", halted, acc, carry);
        end
    endtask

    task automatic test_ldi_keeps_carry();
        step(2'b10);
        step(2'b01);
        total++;
        if ({acc, carry, halted, zero, mem_addr} !== {4'd0, 1'b1, 1'b1, ZF, 4'd5}) begin
            bad++;
            $display("FAIL ldi_carry got acc=%0d c=%0b h=%0b z=%0b pc=%0d want acc=0 c=1 h=1 z=%0b pc=5",
                     acc, carry, halted, zero, mem_addr, ZF);
        end
    endtask

    task automatic test_err();
        step(2'b11);
        total++;
        if ({err, acc, carry, halted, mem_addr} !== {1'b1, 4'd0, 1'b1, 1'b1, 4'd5}) begin
            bad++;
            $display("FAIL err_set got e=%0b acc=%0d c=%0b h=%0b pc=%0d want e=1 acc=0 c=1 h=1 pc=5",
                     err, acc, carry, halted, mem_addr);
        end
        step(2'b00);
        total++;
        if (err !== 1'b1) begin
            bad++;
            $display("FAIL err_sticky got=%0b want=1", err);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        total++;
        if ({err, halted, carry, mem_addr} !== {1'b0, 1'b0, 1'b0, 4'd0}) begin
            bad++;
            $display("FAIL wrap_reset got e=%0b h=%0b c=%0b pc=%0d want 0 0 0 0", err, halted, carry, mem_addr);
        end
        fill_rom(6'b00_0000);
        for (int i = 0; i < 15; i++) begin
            step(2'b10);
            step(2'b01);
        end
        total++;
        if ({mem_addr, acc, zero} !== {4'd15, 4'd0, ZF}) begin
            bad++;
            $display("FAIL wrap_pre got pc=%0d acc=%0d z=%0b want pc=15 acc=0 z=%0b", mem_addr, acc, zero, ZF);
        end
        step(2'b10);
        total++;
        if (mem_addr !== 4'd0) begin
            bad++;
            $display("FAIL wrap_pc got=%0d want=0", mem_addr);
        end
    endtask

    task automatic test_reset_mid_exec();
        fill_rom(6'b00_0000);
        rom[0] = 6'b00_0111;
        rom[1] = 6'b01_1001;
        do_reset();
        step(2'b10);
        step(2'b01);
        total++;
        if ({acc, zero} !== {4'd7, 1'b0}) begin
            bad++;
            $display("FAIL rst_mid_ldi got acc=%0d z=%0b want acc=7 z=0", acc, zero);
        end
        step(2'b10);
        step(2'b01);
        reset = 1'b1;
        step(2'b01);
        reset = 1'b0;
        total++;
        if ({acc, carry, mem_addr, op} !== {4'd0, 1'b0, 4'd0, 2'b00}) begin
            bad++;
            $display("FAIL rst_mid_exec got acc=%0d c=%0b pc=%0d op=%0d want 0 0 0 0", acc, carry, mem_addr, op);
        end
        step(2'b01);
        total++;
        if ({acc, carry} !== {4'd0, 1'b0}) begin
            bad++;
            $display("FAIL rst_lone_exec got acc=%0d c=%0b want acc=0 c=0", acc, carry);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        ctl   = 2'b00;
        fill_rom(6'b00_0000);
        rom[0] = 6'b00_0101;
        rom[1] = 6'b01_0011;
        rom[2] = 6'b01_1010;
        rom[3] = 6'b10_0000;
        rom[4] = 6'b00_0000;
        test_reset();
        test_ldi();
        test_add();
        test_spurious_exec();
        test_halt();
        test_ldi_keeps_carry();
        test_err();
        test_wrap();
        test_reset_mid_exec();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
